// File: rtl/saw_bass_voice_if.sv
// Sample handshake, note controls, shared multiplier/divider ports and output
// sample of the sawtooth bass voice, bundled for the voice and its host.
interface saw_bass_voice_if;
  logic               start;
  logic               finish;
  logic               gate;
  logic               trigger;
  logic [23:0]        freq;
  logic signed [23:0] wave_out;
  logic signed [63:0] mult_p;
  logic signed [31:0] mult_a;
  logic signed [31:0] mult_b;
  logic [47:0]        div_q;
  logic [47:0]        div_n;
  logic [47:0]        div_d;

  modport master (
    output start, gate, trigger, freq, mult_p, div_q,
    input  finish, wave_out, mult_a, mult_b, div_n, div_d
  );

  modport slave (
    input  start, gate, trigger, freq, mult_p, div_q,
    output finish, wave_out, mult_a, mult_b, div_n, div_d
  );
endinterface

// File: rtl/saw_bass_voice.sv
// Monophonic bass voice: phase accumulator, naive saw, Chamberlin SVF lowpass
// with decaying cutoff and an amplitude envelope; one sample per start/finish.
module saw_bass_voice (
  input  logic            clk,
  input  logic            rst_n,
  saw_bass_voice_if.slave bus
);
  localparam logic signed [31:0] Q_DAMP    = 32'sd13981013;
  localparam logic [23:0]        CUT_RST   = 24'd6144000;
  localparam logic [23:0]        CUT_TRIG  = 24'd1280000;
  localparam logic [23:0]        CUT_FLOOR = 24'd102400;
  localparam logic [23:0]        AMP_MAX   = 24'hFFFFFF;

  typedef enum logic [2:0] {
    S_IDLE, S_OSCS, S_SAW, S_LPF, S_BUBBLE, S_AMP, S_FINISH
  } state_t;

  state_t             r_state, w_next;
  logic [2:0]         r_cnt;
  logic [23:0]        r_amp, r_cut, r_porta;
  logic [31:0]        r_acc;
  logic signed [31:0] r_x, r_low, r_band;
  logic signed [23:0] r_wave;
  logic               r_finish;

  logic [38:0]        w_pinc;
  logic [33:0]        w_fprod;
  logic signed [31:0] w_f, w_prod, w_high;
  logic signed [23:0] w_saw;
  logic signed [31:0] w_mult_a, w_mult_b;
  logic               w_unused_div;

  // Glide step: 1/4096 of the remaining distance, never less than one LSB.
  function automatic logic [23:0] porta_step(input logic [23:0] d);
    logic [23:0] s;
    s = d >> 12;
    return (s == 24'd0) ? 24'd1 : s;
  endfunction

  // Cutoff in Q16.8 Hz scaled to Q24 SVF coefficient, clamped just below 1.0.
  function automatic logic [23:0] sat_f(input logic [33:0] p);
    logic [33:0] s;
    s = p >> 6;
    return (s > 34'h0FFFFFF) ? 24'hFFFFFF : s[23:0];
  endfunction

  assign w_pinc  = {15'd0, r_porta} * 39'd22370;
  assign w_fprod = {10'd0, r_cut} * 34'd549;
  assign w_f     = $signed({8'd0, sat_f(w_fprod)});
  assign w_saw   = $signed({r_acc[31:16], 8'h00} - 24'h800000);
  assign w_prod  = 32'(bus.mult_p >>> 24);
  assign w_high  = r_x - r_low - w_prod;
  assign w_unused_div = ^bus.div_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (bus.start) w_next = S_OSCS;
      S_OSCS:   w_next = S_SAW;
      S_SAW:    w_next = S_LPF;
      S_LPF:    if (r_cnt == 3'd6) w_next = S_BUBBLE;
      S_BUBBLE: w_next = S_AMP;
      S_AMP:    w_next = S_FINISH;
      S_FINISH: w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  // Multiplier issue slots; each product is consumed two cycles later.
  always_comb begin
    w_mult_a = '0;
    w_mult_b = '0;
    if (r_state == S_LPF) begin
      case (r_cnt)
        3'd0: begin w_mult_a = w_f;    w_mult_b = r_band; end
        3'd2: begin w_mult_a = Q_DAMP; w_mult_b = r_band; end
        3'd4: begin w_mult_a = w_f;    w_mult_b = w_high; end
        3'd6: begin w_mult_a = r_low;  w_mult_b = $signed({8'd0, r_amp}); end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt    <= '0;
      r_amp    <= '0;
      r_cut    <= CUT_RST;
      r_porta  <= '0;
      r_acc    <= '0;
      r_x      <= '0;
      r_low    <= '0;
      r_band   <= '0;
      r_wave   <= '0;
      r_finish <= 1'b0;
    end else begin
      r_finish <= (r_state == S_AMP);
      case (r_state)
        S_IDLE: if (bus.start) begin
          if (bus.trigger) begin
            r_cut   <= CUT_TRIG;
            r_porta <= bus.freq;
          end else begin
            r_cut <= r_cut - ((r_cut - CUT_FLOOR) >> 12);
            if (bus.freq > r_porta)      r_porta <= r_porta + porta_step(bus.freq - r_porta);
            else if (bus.freq < r_porta) r_porta <= r_porta - porta_step(r_porta - bus.freq);
          end
          if (bus.gate) r_amp <= r_amp + ((AMP_MAX - r_amp) >> 9);
          else          r_amp <= r_amp - (r_amp >> 12);
        end
        S_OSCS: r_acc <= r_acc + 32'(w_pinc >> 6);
        S_SAW:  r_x   <= {{12{w_saw[23]}}, w_saw[23:4]};
        S_LPF: begin
          r_cnt <= (r_cnt == 3'd6) ? 3'd0 : r_cnt + 3'd1;
          if (r_cnt == 3'd2) r_low  <= r_low + w_prod;
          if (r_cnt == 3'd6) r_band <= r_band + w_prod;
        end
        S_AMP:  r_wave <= 24'(bus.mult_p >>> 24);
        default: ;
      endcase
    end
  end

  assign bus.finish   = r_finish;
  assign bus.wave_out = r_wave;
  assign bus.mult_a   = w_mult_a;
  assign bus.mult_b   = w_mult_b;
  assign bus.div_n    = '0;
  assign bus.div_d    = '0;
endmodule

// File: tb/tb_saw_bass_voice.sv
// Bench for saw_bass_voice: shared-multiplier model, sample-level reference
// voice, directed and randomized note sequences.
module tb_saw_bass_voice;
  logic clk = 1'b0;
  logic rst_n;
  saw_bass_voice_if bus ();

  saw_bass_voice dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  // Shared multiplier: two-cycle signed product.
  logic signed [63:0] mp1, mp2;
  always @(posedge clk) begin
    mp1 <= longint'(bus.mult_a) * longint'(bus.mult_b);
    mp2 <= mp1;
  end
  assign bus.mult_p = mp2;
  assign bus.div_q  = 48'hABCDEF012345;

  int n_chk = 0;
  int n_pass = 0;

  task automatic check(input string tag, input longint act, input longint exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, act, exp);
  endtask

  // Reference voice state, advanced once per accepted sample.
  longint m_amp, m_cut, m_porta, m_acc;
  int     m_low, m_band, m_wave;

  task automatic model_reset();
    m_amp = 0; m_cut = 6144000; m_porta = 0; m_acc = 0;
    m_low = 0; m_band = 0; m_wave = 0;
  endtask

  function automatic longint max1(input longint v);
    return (v < 1) ? 1 : v;
  endfunction

  function automatic int prod24(input longint a, input longint b);
    longint p;
    p = a * b;
    return int'(p >>> 24);
  endfunction

  task automatic model_step(input bit g, input bit t, input longint fq);
    longint f, x, p;
    int high;
    logic signed [23:0] w;
    if (t) begin
      m_cut = 1280000;
      m_porta = fq;
    end else begin
      m_cut = m_cut - (m_cut - 102400) / 4096;
      if (fq > m_porta)      m_porta = m_porta + max1((fq - m_porta) / 4096);
      else if (fq < m_porta) m_porta = m_porta - max1((m_porta - fq) / 4096);
    end
    if (g) m_amp = m_amp + (16777215 - m_amp) / 512;
    else   m_amp = m_amp - m_amp / 4096;
    m_acc = (m_acc + (m_porta * 22370) / 64) % 64'sd4294967296;
    x = ((m_acc / 65536) * 256 - 8388608) / 16;
    f = (m_cut * 549) / 64;
    if (f > 16777215) f = 16777215;
    m_low  = m_low + prod24(f, longint'(m_band));
    high   = int'(x) - m_low - prod24(13981013, longint'(m_band));
    m_band = m_band + prod24(f, longint'(high));
    p = longint'(m_low) * m_amp;
    w = 24'(p >>> 24);
    m_wave = int'(w);
  endtask

  // Called at a falling edge with the voice idle; returns at the falling edge
  // of the first idle cycle after the sample.
  task automatic run_sample(input bit g, input bit t, input logic [23:0] fq, input bit hold);
    int old_wave, fin_at;
    bit held_ok, mult_ok, div_ok;
    bus.start = 1'b1; bus.gate = g; bus.trigger = t; bus.freq = fq;
    old_wave = m_wave;
    model_step(g, t, longint'(fq));
    fin_at = 0; held_ok = 1'b1; mult_ok = 1'b1; div_ok = 1'b1;
    for (int n = 1; n <= 12; n++) begin
      @(negedge clk);
      if (n == 1) begin
        bus.start   = hold;
        bus.gate    = 1'($urandom);
        bus.trigger = 1'($urandom);
        bus.freq    = 24'($urandom);
      end
      if (bus.finish && fin_at == 0) fin_at = n;
      if (n <= 11 && int'(bus.wave_out) != old_wave) held_ok = 1'b0;
      if ((n <= 2 || n >= 10) && (bus.mult_a != 0 || bus.mult_b != 0)) mult_ok = 1'b0;
      if (bus.div_n != 0 || bus.div_d != 0) div_ok = 1'b0;
    end
    check("finish_latency", longint'(fin_at), 12);
    check("wave_hold", longint'(held_ok), 1);
    check("wave_out", longint'(bus.wave_out), longint'(m_wave));
    check("mult_idle_zero", longint'(mult_ok), 1);
    check("div_zero", longint'(div_ok), 1);
    @(negedge clk);
    check("finish_width", longint'(bus.finish), 0);
    if (!hold) repeat ($urandom_range(0, 2)) @(negedge clk);
  endtask

  function automatic logic [23:0] rand_freq();
    if ($urandom_range(0, 3) == 0) return 24'($urandom);
    return 24'($urandom_range(5120, 51200));
  endfunction

  initial begin
    int fin_seen;
    longint dc_exp, dc_err;
    rst_n = 1'b1;
    bus.start = 1'b0; bus.gate = 1'b0; bus.trigger = 1'b0; bus.freq = '0;
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_finish", longint'(bus.finish), 0);
    check("rst_wave", longint'(bus.wave_out), 0);
    rst_n = 1'b1;
    model_reset();
    @(negedge clk);

    // First triggered note, glide up, equal pitch, release.
    run_sample(1'b1, 1'b1, 24'd112640, 1'b0);
    run_sample(1'b1, 1'b0, 24'd225280, 1'b0);
    run_sample(1'b1, 1'b0, 24'd225280, 1'b1);
    run_sample(1'b1, 1'b0, 24'(m_porta), 1'b0);
    run_sample(1'b0, 1'b0, 24'(m_porta), 1'b1);
    for (int i = 0; i < 20; i++) run_sample(1'b1, 1'b0, rand_freq(), 1'($urandom));

    // Asynchronous reset in the middle of the filter.
    bus.start = 1'b1; bus.gate = 1'b1; bus.trigger = 1'b0; bus.freq = 24'd60000;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_finish", longint'(bus.finish), 0);
    check("midrst_wave", longint'(bus.wave_out), 0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    fin_seen = 0;
    repeat (14) begin
      @(negedge clk);
      if (bus.finish) fin_seen++;
    end
    check("midrst_no_finish", longint'(fin_seen), 0);

    // DC settling with zero pitch.
    run_sample(1'b1, 1'b1, 24'd0, 1'b0);
    for (int i = 0; i < 300; i++) run_sample(1'b1, 1'b0, 24'd0, 1'($urandom));
    dc_exp = (-64'sd524288 * m_amp) >>> 24;
    dc_err = longint'(bus.wave_out) - dc_exp;
    if (dc_err < 0) dc_err = -dc_err;
    check("dc_settle", longint'(dc_err <= 2048), 1);
    run_sample(1'b0, 1'b0, 24'd0, 1'b0);

    // Randomized note sequences.
    for (int i = 0; i < 1500; i++)
      run_sample(($urandom_range(0, 3) != 0), ($urandom_range(0, 15) == 0),
                 rand_freq(), 1'($urandom));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
